// File: rtl/mul_fu_pipe.sv
// Pipelined multiply unit: partial-product stage, pairwise adder tree, in-order result queue drained over the CDB.
// Optional MUL_FU_FLUSH_EN adds a flush port that clears the unit like RST without holding issue_ready low.
module mul_fu_pipe #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned LABEL_W  = 4,
  parameter int unsigned OQ_DEPTH = 8
) (
  input  logic               clk,
  input  logic               RST,
  input  logic               issue_valid,
  output logic               issue_ready,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   data_a,
  input  logic [WIDTH-1:0]   data_b,
  input  logic [LABEL_W-1:0] label_in,
  output logic               cdb_req,
  input  logic               cdb_ack,
  output logic [WIDTH-1:0]   cdb_data,
  output logic [LABEL_W-1:0] cdb_label
`ifdef MUL_FU_FLUSH_EN
  ,
  input  logic               flush
`endif
);

  localparam int unsigned LAT   = 1 + $clog2(WIDTH);
  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned NODES = 2 * WIDTH - 1;
  localparam int unsigned QAW   = (OQ_DEPTH > 1) ? $clog2(OQ_DEPTH) : 1;
  localparam int unsigned CW    = $clog2(OQ_DEPTH + 1);

  typedef enum logic [1:0] {
    OP_MUL   = 2'b00,
    OP_MULH  = 2'b01,
    OP_MULHU = 2'b10,
    OP_MUL3  = 2'b11
  } op_e;

  logic clr;
`ifdef MUL_FU_FLUSH_EN
  assign clr = RST || flush;
`else
  assign clr = RST;
`endif

  logic          pop_req;
  logic          accept;
  logic          pop;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_after;

  // A same-cycle grant frees its credit before the issue decision is made.
  always_comb begin
    pop_req     = cdb_req && cdb_ack;
    cnt_after   = cnt - CW'(pop_req);
    issue_ready = !RST && (cnt_after < CW'(OQ_DEPTH));
    accept      = issue_valid && issue_ready && !clr;
    pop         = pop_req && !clr;
  end

  op_e           op_in;
  logic [PW-1:0] a_ext;
  logic [PW-1:0] pp0 [WIDTH];

  always_comb begin
    op_in = op_e'(op);
    a_ext = (op_in == OP_MULH) ? {{WIDTH{data_a[WIDTH-1]}}, data_a} : {{WIDTH{1'b0}}, data_a};
    for (int unsigned i = 0; i < WIDTH; i++) begin
      pp0[i] = data_b[i] ? (a_ext << i) : '0;
    end
    // Signed b: its top bit carries negative weight.
    if (op_in == OP_MULH && data_b[WIDTH-1]) begin
      pp0[WIDTH-1] = -(a_ext << (WIDTH - 1));
    end
  end

  // Level k of the tree occupies WIDTH>>k consecutive nodes starting here.
  function automatic int unsigned lvl_off(input int unsigned k);
    return 2 * WIDTH - 2 * (WIDTH >> k);
  endfunction

  logic [PW-1:0]      tree [NODES];
  logic [LAT-1:0]     vld;
  logic [LABEL_W-1:0] slbl [LAT];
  op_e                sop  [LAT];

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < WIDTH; i++) begin
      tree[i] <= pp0[i];
    end
    slbl[0] <= label_in;
    sop[0]  <= op_in;
    for (int unsigned k = 1; k < LAT; k++) begin
      slbl[k] <= slbl[k-1];
      sop[k]  <= sop[k-1];
      for (int unsigned j = 0; j < WIDTH / 2; j++) begin
        if (j < (WIDTH >> k)) begin
          tree[lvl_off(k) + j] <= tree[lvl_off(k-1) + j] + tree[lvl_off(k-1) + j + (WIDTH >> k)];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      vld <= '0;
    end else begin
      vld <= {vld[LAT-2:0], accept};
    end
  end

  logic [PW-1:0]    fin;
  logic [WIDTH-1:0] res;
  logic             wr;

  always_comb begin
    fin = tree[NODES-1];
    res = (sop[LAT-1] == OP_MULH || sop[LAT-1] == OP_MULHU) ? fin[PW-1:WIDTH] : fin[WIDTH-1:0];
    wr  = vld[LAT-1] && !clr;
  end

  logic [WIDTH-1:0]   q_data [OQ_DEPTH];
  logic [LABEL_W-1:0] q_lbl  [OQ_DEPTH];
  logic [QAW-1:0]     head;
  logic [QAW-1:0]     tail;
  logic [CW-1:0]      qcnt;

  function automatic logic [QAW-1:0] nxt(input logic [QAW-1:0] p);
    return (p == QAW'(OQ_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (wr) begin
      q_data[tail] <= res;
      q_lbl[tail]  <= slbl[LAT-1];
    end
  end

  // Credits are taken at accept, so a tree output always finds a free slot.
  always_ff @(posedge clk) begin
    if (clr) begin
      head <= '0;
      tail <= '0;
      qcnt <= '0;
      cnt  <= '0;
    end else begin
      if (wr) begin
        tail <= nxt(tail);
      end
      if (pop) begin
        head <= nxt(head);
      end
      qcnt <= qcnt + CW'(wr) - CW'(pop);
      cnt  <= cnt + CW'(accept) - CW'(pop);
    end
  end

  always_comb begin
    cdb_req   = (qcnt != '0);
    cdb_data  = cdb_req ? q_data[head] : '0;
    cdb_label = cdb_req ? q_lbl[head] : '0;
  end

endmodule

// File: tb/tb_mul_fu_pipe.sv
// Self-checking bench for mul_fu_pipe: directed table, multi-cycle corner sequences and random traffic vs a queue model.
module tb_mul_fu_pipe;

  localparam int W     = 32;
  localparam int LW    = 4;
  localparam int DEPTH = 8;
  localparam int LAT   = 6;

  logic          clk = 1'b0;
  logic          RST;
  logic          issue_valid;
  logic          issue_ready;
  logic [1:0]    op;
  logic [W-1:0]  data_a;
  logic [W-1:0]  data_b;
  logic [LW-1:0] label_in;
  logic          cdb_req;
  logic          cdb_ack;
  logic [W-1:0]  cdb_data;
  logic [LW-1:0] cdb_label;
`ifdef MUL_FU_FLUSH_EN
  logic          flush;
`endif

  always #5 clk = ~clk;

  mul_fu_pipe #(.WIDTH(W), .LABEL_W(LW), .OQ_DEPTH(DEPTH)) dut (
    .clk(clk),
    .RST(RST),
    .issue_valid(issue_valid),
    .issue_ready(issue_ready),
    .op(op),
    .data_a(data_a),
    .data_b(data_b),
    .label_in(label_in),
    .cdb_req(cdb_req),
    .cdb_ack(cdb_ack),
    .cdb_data(cdb_data),
    .cdb_label(cdb_label)
`ifdef MUL_FU_FLUSH_EN
    ,
    .flush(flush)
`endif
  );

  typedef struct {
    logic [W-1:0]  d;
    logic [LW-1:0] l;
    int            age;
  } infl_t;

  typedef struct {
    logic [W-1:0]  d;
    logic [LW-1:0] l;
  } res_t;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } vec_t;

  infl_t infl[$];
  res_t  outq[$];

  int            total = 0;
  int            bad   = 0;
  bit            last_rdy;
  bit            last_req;
  logic [LW-1:0] last_lbl;

  function automatic logic [W-1:0] ref_mul(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    longint          sa, sb, sp;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (o)
      2'b01: begin
        sp = sa * sb;
        return sp[63:32];
      end
      2'b10: begin
        up = ua * ub;
        return up[63:32];
      end
      default: begin
        up = ua * ub;
        return up[31:0];
      end
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive at negedge, compare against the model, advance the model at posedge.
  task automatic step(input bit v, input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [LW-1:0] l, input bit ack, input bit rst_i, input bit fl);
    bit            exp_req, exp_rdy, acc, pop_m;
    logic [W-1:0]  exp_data;
    logic [LW-1:0] exp_lbl;
    int            cnt;
    issue_valid = v;
    op          = o;
    data_a      = a;
    data_b      = b;
    label_in    = l;
    cdb_ack     = ack;
    RST         = rst_i;
`ifdef MUL_FU_FLUSH_EN
    flush       = fl;
`endif
    #1;
    exp_req  = (outq.size() != 0);
    exp_data = exp_req ? outq[0].d : '0;
    exp_lbl  = exp_req ? outq[0].l : '0;
    cnt      = infl.size() + outq.size();
    pop_m    = exp_req && ack;
    exp_rdy  = !rst_i && ((cnt - int'(pop_m)) < DEPTH);
    check("req", 64'(cdb_req), 64'(exp_req));
    check("data", 64'(cdb_data), 64'(exp_data));
    check("label", 64'(cdb_label), 64'(exp_lbl));
    check("ready", 64'(issue_ready), 64'(exp_rdy));
    last_rdy = issue_ready;
    last_req = cdb_req;
    last_lbl = cdb_label;
    acc = v && exp_rdy && !rst_i && !fl;
    @(posedge clk);
    if (rst_i || fl) begin
      infl.delete();
      outq.delete();
    end else begin
      if (pop_m) void'(outq.pop_front());
      foreach (infl[i]) infl[i].age++;
      while (infl.size() > 0 && infl[0].age >= LAT) begin
        outq.push_back('{d: infl[0].d, l: infl[0].l});
        void'(infl.pop_front());
      end
      if (acc) infl.push_back('{d: ref_mul(o, a, b), l: l, age: 0});
    end
    @(negedge clk);
  endtask

  task automatic idle(input bit ack);
    step(1'b0, 2'b00, '0, '0, '0, ack, 1'b0, 1'b0);
  endtask

  task automatic wait_req(output int n);
    n = 0;
    while (!cdb_req && n < 20) begin
      idle(1'b0);
      n++;
    end
  endtask

  vec_t          tbl[14];
  int            n;
  int            popped;
  logic [LW-1:0] lastl;
  int            seen_cyc[$];
  logic [LW-1:0] seen_lbl[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{2'b00, 32'd7,          32'd6,          32'd42};
    tbl[1]  = '{2'b00, 32'hFFFFFFFE,   32'd3,          32'hFFFFFFFA};
    tbl[2]  = '{2'b01, 32'hFFFFFFFE,   32'd3,          32'hFFFFFFFF};
    tbl[3]  = '{2'b10, 32'hFFFFFFFE,   32'd3,          32'h00000002};
    tbl[4]  = '{2'b11, 32'hFFFFFFFE,   32'd3,          32'hFFFFFFFA};
    tbl[5]  = '{2'b01, 32'h80000000,   32'h80000000,   32'h40000000};
    tbl[6]  = '{2'b10, 32'h80000000,   32'h80000000,   32'h40000000};
    tbl[7]  = '{2'b00, 32'h80000000,   32'h80000000,   32'h00000000};
    tbl[8]  = '{2'b00, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000001};
    tbl[9]  = '{2'b01, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000000};
    tbl[10] = '{2'b10, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE};
    tbl[11] = '{2'b01, 32'h7FFFFFFF,   32'h80000000,   32'hC0000000};
    tbl[12] = '{2'b10, 32'h7FFFFFFF,   32'h80000000,   32'h3FFFFFFF};
    tbl[13] = '{2'b01, 32'd5,          32'hFFFFFFFD,   32'hFFFFFFFF};

    RST = 1'b1; issue_valid = 1'b0; op = '0; data_a = '0; data_b = '0; label_in = '0; cdb_ack = 1'b0;
`ifdef MUL_FU_FLUSH_EN
    flush = 1'b0;
`endif
    repeat (3) @(negedge clk);

    // Reset state, then first cycle out of reset.
    step(1'b1, 2'b00, 32'd1, 32'd1, '0, 1'b1, 1'b1, 1'b0);
    check("rst_ready_low", 64'(last_rdy), 64'd0);
    check("rst_req_low", 64'(last_req), 64'd0);
    idle(1'b0);
    check("ready_after_rst", 64'(last_rdy), 64'd1);

    // Directed table: latency, value and label of single ops.
    for (int i = 0; i < 14; i++) begin
      step(1'b1, tbl[i].op, tbl[i].a, tbl[i].b, LW'(i), 1'b0, 1'b0, 1'b0);
      check("tbl_accept", 64'(last_rdy), 64'd1);
      wait_req(n);
      check("tbl_latency", 64'(n), 64'(LAT));
      check("tbl_data", 64'(cdb_data), 64'(tbl[i].exp));
      check("tbl_label", 64'(cdb_label), 64'(i));
      idle(1'b1);
      check("tbl_req_drop", 64'(cdb_req), 64'd0);
    end

    // Back-to-back with ack held: 8 in-order results on consecutive cycles.
    for (int c = 0; c < 30; c++) begin
      step(c < 8, 2'($urandom), $urandom, $urandom, LW'(c), 1'b1, 1'b0, 1'b0);
      if (c < 8) check("b2b_ready", 64'(last_rdy), 64'd1);
      if (last_req) begin
        seen_cyc.push_back(c);
        seen_lbl.push_back(last_lbl);
      end
    end
    check("b2b_count", 64'(seen_lbl.size()), 64'd8);
    for (int k = 0; k < seen_lbl.size(); k++) begin
      check("b2b_order", 64'(seen_lbl[k]), 64'(k));
      check("b2b_consec", 64'(seen_cyc[k]), 64'(seen_cyc[0] + k));
    end

    // Backpressure: 8 credits, full, a same-cycle ack admits the 9th op.
    for (int c = 0; c < 8; c++) begin
      step(1'b1, 2'($urandom), $urandom, $urandom, LW'(c), 1'b0, 1'b0, 1'b0);
      check("bp_ready", 64'(last_rdy), 64'd1);
    end
    step(1'b1, 2'b00, 32'd3, 32'd3, 4'd9, 1'b0, 1'b0, 1'b0);
    check("bp_full", 64'(last_rdy), 64'd0);
    check("bp_head_ready", 64'(cdb_req), 64'd1);
    step(1'b1, 2'b00, 32'd11, 32'd13, 4'd8, 1'b1, 1'b0, 1'b0);
    check("bp_ack_frees", 64'(last_rdy), 64'd1);
    step(1'b1, 2'b00, 32'd3, 32'd3, 4'd10, 1'b0, 1'b0, 1'b0);
    check("bp_full_again", 64'(last_rdy), 64'd0);
    popped = 0;
    lastl  = '0;
    for (int c = 0; c < 40; c++) begin
      idle(1'b1);
      if (last_req) begin
        popped++;
        lastl = last_lbl;
      end
    end
    check("bp_drained", 64'(popped), 64'd8);
    check("bp_last_label", 64'(lastl), 64'd8);

    // Reset with three ops in flight; accept and ack in the reset cycle are ignored.
    for (int c = 0; c < 3; c++) step(1'b1, 2'b00, $urandom, $urandom, LW'(c), 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'b00, 32'd2, 32'd2, 4'd3, 1'b1, 1'b1, 1'b0);
    check("rstmid_ready", 64'(last_rdy), 64'd0);
    n = 0;
    for (int c = 0; c < 12; c++) begin
      idle(1'b1);
      if (last_req) n++;
    end
    check("rstmid_no_req", 64'(n), 64'd0);
    check("rstmid_ready_after", 64'(last_rdy), 64'd1);
    step(1'b1, 2'b00, 32'd7, 32'd6, 4'd5, 1'b0, 1'b0, 1'b0);
    wait_req(n);
    check("rstmid_latency", 64'(n), 64'(LAT));
    check("rstmid_data", 64'(cdb_data), 64'd42);
    check("rstmid_label", 64'(cdb_label), 64'd5);
    idle(1'b1);

`ifdef MUL_FU_FLUSH_EN
    // Flush on the same edge as an accept and an ack.
    step(1'b1, 2'b00, 32'd4, 32'd4, 4'd1, 1'b0, 1'b0, 1'b0);
    wait_req(n);
    step(1'b1, 2'b00, 32'd5, 32'd5, 4'd2, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'b00, 32'd6, 32'd6, 4'd3, 1'b1, 1'b0, 1'b1);
    check("flush_ready_not_forced", 64'(last_rdy), 64'd1);
    check("flush_req_clear", 64'(cdb_req), 64'd0);
    n = 0;
    for (int c = 0; c < 10; c++) begin
      idle(1'b1);
      if (last_req) n++;
    end
    check("flush_nothing_out", 64'(n), 64'd0);
    check("flush_ready_after", 64'(last_rdy), 64'd1);
`endif

    // Random traffic against the queue model.
    for (int c = 0; c < 400; c++) begin
      logic [W-1:0] ra, rb;
      ra = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom;
      step(($urandom_range(0, 3) != 0), 2'($urandom), ra, rb, LW'($urandom), 1'($urandom), 1'b0, 1'b0);
    end
    for (int c = 0; c < 30; c++) idle(1'b1);
    check("final_empty", 64'(cdb_req), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
